rr_arbiter_8_64bit: RTL
=======================

Name: rr_arbiter_8_64bit

Overview:
- Round-robin arbiter that shares one 64-bit resource path among 8 requesters.
- Owns the 3-bit select of an internal mux_8_64bit and drives the selected requester's data onto OUT.
- Sits in front of shared 64-bit resources in the 5-stage pipeline, e.g. a shared memory or result bus.
- Grant is held until the resource signals DONE, or the requester withdraws.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; only used with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ  input  8  request vector; bit i = requester i.
- IN0..IN7  input  64 each  requester data.
- DONE  input  1  resource finished current transaction; sampled only while VALID=1.
- GNT  output  8  one-hot grant, registered.
- SEL  output  3  index of the granted requester, registered; drives the mux select.
- OUT  output  64  IN[SEL], combinational through mux_8_64bit.
- VALID  output  1  a grant is active (state GRANT).
- TIMEOUT  output  1  one-cycle pulse on forced release.

Behaviour:
- State machine has two states: IDLE and GRANT. A 3-bit LAST pointer holds the most recently granted index.
- Reset values:
  - state=IDLE, GNT=8'h00, SEL=3'd0, VALID=0, TIMEOUT=0.
  - LAST=3'd7, so index 0 has first priority.
  - Hold counter=0.
- Round-robin pick:
  - Search indices LAST+1, LAST+2, … mod 8.
  - The first i with REQ[i]=1 wins.
  - The search wraps from 7 to 0.
- IDLE:
  - If REQ!=0, go to GRANT at the next edge with GNT=onehot(pick), SEL=pick, LAST=pick. Latency is 1 cycle from REQ to GNT.
  - If REQ=0, stay in IDLE. GNT=0, and SEL keeps its last value.
- GRANT, release event: DONE=1, or REQ[SEL]=0 (withdrawal).
  - At the next edge, run the pick over the current REQ with LAST already equal to SEL.
  - If any request is present, grant the winner back-to-back with no idle cycle. VALID stays 1.
  - If no request is present, go to IDLE.
  - A requester that just released may be re-granted only if it is the sole requester.
- GRANT, no release event: GNT, SEL and OUT hold. New requests from other indices have no effect.
- DONE while VALID=0 is ignored.
- RESET takes priority over every other event. An active grant is dropped at the next edge: GNT=0 in the cycle after RESET is sampled, and LAST returns to 7.
- OUT always equals the IN selected by SEL, including in IDLE. Consumers qualify it with VALID.
- GNT is always either zero or one-hot. GNT!=0 exactly when VALID=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit hold counter clears on every new grant and increments each GRANT cycle without a release event.
  - When the counter reaches MAX_HOLD-1 with no release event, the grant is forced off at the next edge. Re-arbitration follows the normal release rule.
  - TIMEOUT pulses high for 1 cycle, coincident with the edge that changes GNT.
  - A DONE in the same cycle counts as a normal release, and TIMEOUT stays 0.
- Without the macro: no counter exists, TIMEOUT is tied to 0, and a grant is held indefinitely.

Test Plan:
- Reset, then REQ=8'h01 with IN0=64'hA5A5_0000_0000_0001 → next cycle: GNT=8'h01, SEL=0, VALID=1, OUT=64'hA5A5_0000_0000_0001. Assert DONE with REQ=0 → GNT=0, VALID=0.
- REQ=8'hFF held, DONE pulsed every 2nd cycle → grants in order 0,1,2,…,7,0. No idle cycle between grants, and GNT is always one-hot.
- LAST=6, REQ=8'h41 (bits 6 and 0), DONE → wrap: next grant goes to index 0, not 6. With REQ=8'h40 alone, 6 is re-granted.
- Grant to 3, then REQ[3] dropped without DONE → release at the next edge. With REQ=8'h20 pending, GNT=8'h20, SEL=5.
- RESET asserted mid-grant (GNT=8'h10) → next cycle: GNT=0, VALID=0, SEL=0. The first grant after reset with REQ=8'h90 goes to index 4.
- ARB_TIMEOUT_EN, MAX_HOLD=4, REQ=8'h06 with no DONE → grant 1 lasts 4 cycles, then TIMEOUT=1 for one cycle and GNT=8'h04. Without the macro, GNT=8'h02 holds for more than 20 cycles and TIMEOUT stays 0.

Source files
------------

// File: rtl/rr_arbiter_8_64bit.sv
// 8-way round-robin arbiter owning the select of a 64-bit 8:1 data mux.
// Define ARB_TIMEOUT_EN to force-release grants held for MAX_HOLD cycles.

module mux_8_64bit (
  input  logic [2:0]  SEL,
  input  logic [63:0] IN0,
  input  logic [63:0] IN1,
  input  logic [63:0] IN2,
  input  logic [63:0] IN3,
  input  logic [63:0] IN4,
  input  logic [63:0] IN5,
  input  logic [63:0] IN6,
  input  logic [63:0] IN7,
  output logic [63:0] OUT
);
  always_comb begin
    OUT = '0;
    case (SEL)
      3'd0: OUT = IN0;
      3'd1: OUT = IN1;
      3'd2: OUT = IN2;
      3'd3: OUT = IN3;
      3'd4: OUT = IN4;
      3'd5: OUT = IN5;
      3'd6: OUT = IN6;
      default: OUT = IN7;
    endcase
  end
endmodule

module rr_arbiter_8_64bit #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  REQ,
  input  logic [63:0] IN0,
  input  logic [63:0] IN1,
  input  logic [63:0] IN2,
  input  logic [63:0] IN3,
  input  logic [63:0] IN4,
  input  logic [63:0] IN5,
  input  logic [63:0] IN6,
  input  logic [63:0] IN7,
  input  logic        DONE,
  output logic [7:0]  GNT,
  output logic [2:0]  SEL,
  output logic [63:0] OUT,
  output logic        VALID,
  output logic        TIMEOUT
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;
  logic [2:0] pick, idx;
  logic       found;
  logic       release_ev;
  logic       force_rel;

  // Search starts one past the last winner, so the previous owner comes last.
  always_comb begin
    pick  = last_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = last_q + 3'(k);
      if (!found && REQ[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign release_ev = DONE || !REQ[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  assign force_rel = (state_q == GRANT) && !release_ev && (cnt_q == HOLD_LAST);
  assign TIMEOUT   = timeout_q;
`else
  assign force_rel = 1'b0;
  assign TIMEOUT   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d = GRANT;
          gnt_d   = 8'(1) << pick;
          sel_d   = pick;
          last_d  = pick;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: begin
        if (release_ev || force_rel) begin
`ifdef ARB_TIMEOUT_EN
          timeout_d = force_rel;
          cnt_d     = '0;
`endif
          if (found) begin
            gnt_d  = 8'(1) << pick;
            sel_d  = pick;
            last_d = pick;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= 3'd7;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign GNT   = gnt_q;
  assign SEL   = sel_q;
  assign VALID = (state_q == GRANT);

  mux_8_64bit u_mux (
    .SEL (sel_q),
    .IN0 (IN0),
    .IN1 (IN1),
    .IN2 (IN2),
    .IN3 (IN3),
    .IN4 (IN4),
    .IN5 (IN5),
    .IN6 (IN6),
    .IN7 (IN7),
    .OUT (OUT)
  );
endmodule
